// File: rtl/sipo_frame_ctrl.sv
// Frame controller for the SIPO shift-register datapath: gates the shift
// enable for one WIDTH-bit frame, then hands the word to a holding register
// with a valid/ready handshake and a sticky overrun flag.
//
// state | meaning
// IDLE  | waiting for start1; bit_vld and abort1 ignored
// SHIFT | collecting qualified bits; abort1 drops the partial word
module sipo_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk1,
    input  logic             rstn1,
    input  logic             start1,
    input  logic             abort1,
    input  logic             in1,
    input  logic             bit_vld,
    output logic             shift_en,
    output logic [CNTW-1:0]  cnt,
    output logic [WIDTH-1:0] pout,
    output logic             pvld,
    input  logic             prdy,
    output logic             busy,
    output logic             ovr,
    input  logic             clr_ovr
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Only WIDTH-1 bits need storing; the final bit is taken straight from in1.
    logic [WIDTH-2:0] sreg;
    logic [WIDTH-1:0] word;
    logic             last_bit;
    logic             done;
    logic             load;
    logic             drop;

    assign word     = {sreg, in1};
    assign last_bit = (cnt == CNTW'(WIDTH - 1));

    // Word completion either loads the holding register or, when the old
    // word is still pending and not being drained, is counted as an overrun.
    assign load = done && (!pvld || prdy);
    assign drop = done && pvld && !prdy;

    // State register.
    always_ff @(posedge clk1 or negedge rstn1) begin
        if (!rstn1) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and shift gating; abort1 beats a coincident final bit.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start1) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (abort1) begin
                    state_d = IDLE;
                end else if (bit_vld) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // Bit counter and partial-word shift register.
    always_ff @(posedge clk1 or negedge rstn1) begin
        if (!rstn1) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (state_q == IDLE) begin
            if (start1) begin
                cnt  <= '0;
                sreg <= '0;
            end
        end else if (abort1) begin
            cnt <= '0;
        end else if (shift_en) begin
            if (last_bit) begin
                cnt <= '0;
            end else begin
                cnt  <= cnt + CNTW'(1);
                sreg <= word[WIDTH-2:0];
            end
        end
    end

    // Holding register: a load on a draining edge keeps pvld high.
    always_ff @(posedge clk1 or negedge rstn1) begin
        if (!rstn1) begin
            pout <= '0;
            pvld <= 1'b0;
        end else if (load) begin
            pout <= word;
            pvld <= 1'b1;
        end else if (pvld && prdy) begin
            pvld <= 1'b0;
        end
    end

    // Sticky overrun; a new drop wins over a coincident clear.
    always_ff @(posedge clk1 or negedge rstn1) begin
        if (!rstn1) begin
            ovr <= 1'b0;
        end else if (drop) begin
            ovr <= 1'b1;
        end else if (clr_ovr) begin
            ovr <= 1'b0;
        end
    end

endmodule
